// File: rtl/sram_stage_sequencer.sv
// sram_stage_sequencer: runs SRAM-master stages in order, owning the SRAM bus while a stage runs
// and handing it to the default (display/UART) channel otherwise; per-stage timeout with sticky error.
module sram_stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter logic [31:0] TIMEOUT = 32'd50000000
) (
  input  logic                              CLOCK_50_I,
  input  logic                              resetn,
  input  logic                              go,
  input  logic                              abort,
  input  logic [NUM_STAGES-1:0]             skip_mask,
  input  logic [NUM_STAGES-1:0]             stage_done,
  input  logic [NUM_STAGES*ADDR_W-1:0]      stage_address,
  input  logic [NUM_STAGES-1:0]             stage_we_n,
  input  logic [NUM_STAGES*DATA_W-1:0]      stage_write_data,
  input  logic [ADDR_W-1:0]                 dflt_address,
  input  logic                              dflt_we_n,
  input  logic [DATA_W-1:0]                 dflt_write_data,
  output logic [ADDR_W-1:0]                 SRAM_address,
  output logic                              SRAM_we_n,
  output logic [DATA_W-1:0]                 SRAM_write_data,
  output logic [NUM_STAGES-1:0]             stage_start,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [$clog2(NUM_STAGES+1)-1:0]   err_stage,
  output logic [31:0]                       run_cycles
);
  localparam int IW = $clog2(NUM_STAGES+1);
  localparam logic [2:0] S_IDLE = 3'd0, S_SELECT = 3'd1, S_RUN = 3'd2, S_FINISH = 3'd3, S_FAIL = 3'd4;
  logic [2:0]            r_state;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_skip;
  logic [NUM_STAGES-1:0] r_start;
  logic [31:0]           r_timer;
  logic                  r_error;
  logic [IW-1:0]         r_err_stage;
  logic [31:0]           r_run_cycles;
  logic                  w_run;
  logic [31:0]           w_sel;
  assign w_run = r_state == S_RUN;
  assign w_sel = 32'(r_idx);
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_FINISH;
  assign error = r_error;
  assign err_stage = r_err_stage;
  assign run_cycles = r_run_cycles;
  assign stage_start = r_start;
  // bus ownership follows the registered state only, so the mux never glitches on stage inputs
  assign SRAM_address = w_run ? stage_address[w_sel*ADDR_W +: ADDR_W] : dflt_address;
  assign SRAM_we_n = w_run ? stage_we_n[r_idx] : dflt_we_n;
  assign SRAM_write_data = w_run ? stage_write_data[w_sel*DATA_W +: DATA_W] : dflt_write_data;
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_idx <= '0;
      r_skip <= '0;
      r_start <= '0;
      r_timer <= '0;
      r_error <= 1'b0;
      r_err_stage <= '0;
      r_run_cycles <= '0;
    end else begin
      if (busy && r_run_cycles != 32'hFFFFFFFF) r_run_cycles <= r_run_cycles + 32'd1;
      case (r_state)
        S_IDLE: if (go) begin
          r_skip <= skip_mask;
          r_idx <= '0;
          r_error <= 1'b0;
          r_run_cycles <= '0;
          r_state <= S_SELECT;
        end
        S_SELECT:
          if (r_idx == IW'(NUM_STAGES)) r_state <= S_FINISH;
          else if (r_skip[r_idx]) r_idx <= r_idx + 1'b1;
          else begin
            r_start <= NUM_STAGES'(1) << r_idx;
            r_timer <= '0;
            r_state <= S_RUN;
          end
        S_RUN:
          if (stage_done[r_idx]) begin
            r_start <= '0;
            r_idx <= r_idx + 1'b1;
            r_state <= S_SELECT;
          end else if (abort) begin
            r_start <= '0;
            r_state <= S_IDLE;
          end else if (r_timer == TIMEOUT - 32'd1) begin
            r_start <= '0;
            r_error <= 1'b1;
            r_err_stage <= r_idx;
            r_state <= S_FAIL;
          end else r_timer <= r_timer + 32'd1;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
